shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter_pkg.sv | 18 +
 rtl/shift_arbiter_shift_core.sv | 30 +++
 rtl/shift_arbiter.sv | 111 +++++++++++
 tb/tb_shift_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the two-requester shift arbiter: requester IDs,
// datapath widths and the operand bundle routed to the shared shift core.
package shift_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;
    localparam int NUM_REQ = 2;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MDV = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  amt;
        logic              arith;
    } shift_op_t;

endpackage

// File: rtl/shift_arbiter_shift_core.sv
// Purely combinational 32-bit right shifter; arith selects sign fill, else zero fill.
module shift_core
    import shift_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    input  logic [AMT_W-1:0]  amt_i,
    input  logic              arith_i,
    output logic [DATA_W-1:0] result_o
);

    localparam logic [DATA_W-1:0] ALL_ONES = '1;

    logic [DATA_W-1:0] fill_mask;
    logic [DATA_W-1:0] acc;

    assign fill_mask = {DATA_W{arith_i & data_i[DATA_W-1]}};

    // Log shifter: stage i shifts by 2**i and back-fills the vacated top bits.
    always_comb begin
        acc = data_i;
        for (int i = 0; i < AMT_W; i++) begin
            if (amt_i[i]) begin
                acc = (acc >> (1 << i)) | (fill_mask & ~(ALL_ONES >> (1 << i)));
            end
        end
    end

    assign result_o = acc;

endmodule

// File: rtl/shift_arbiter.sv
// Two requesters (ALU, multdiv) share one shift core; round-robin arbitration
// with optional grant locking and a one-cycle registered response.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter bit RESET_PRIO = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [DATA_W-1:0]    req_data0,
    input  logic [DATA_W-1:0]    req_data1,
    input  logic [AMT_W-1:0]     req_amt0,
    input  logic [AMT_W-1:0]     req_amt1,
    input  logic [NUM_REQ-1:0]   req_arith,
    input  logic [NUM_REQ-1:0]   req_lock,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [DATA_W-1:0]    rsp_data
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOCKED0 = 2'd1;
    localparam logic [1:0] ST_LOCKED1 = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              rsp_valid_q;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic              xfer;
    logic              sel;
    shift_op_t         op;
    logic [DATA_W-1:0] shift_result;

    always_comb begin
        req_ready = '0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid == 2'b11) begin
                        req_ready = last_grant_q ? 2'b01 : 2'b10;
                    end else begin
                        req_ready = req_valid;
                    end
                end
                ST_LOCKED0: req_ready = {1'b0, req_valid[0]};
                ST_LOCKED1: req_ready = {req_valid[1], 1'b0};
                default:    req_ready = '0;
            endcase
        end
    end

    assign xfer = |req_ready;
    assign sel  = req_ready[1];

    assign op = sel ? '{data: req_data1, amt: req_amt1, arith: req_arith[1]}
                    : '{data: req_data0, amt: req_amt0, arith: req_arith[0]};

    shift_core u_core (
        .data_i   (op.data),
        .amt_i    (op.amt),
        .arith_i  (op.arith),
        .result_o (shift_result)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        if (xfer) begin
            last_grant_d = sel;
            rsp_id_d     = sel;
            rsp_data_d   = shift_result;
            if (req_lock[sel]) begin
                state_d = sel ? ST_LOCKED1 : ST_LOCKED0;
            end else begin
                state_d = ST_IDLE;
            end
        end else if ((state_q == ST_LOCKED0 && !req_valid[0]) ||
                     (state_q == ST_LOCKED1 && !req_valid[1])) begin
            // Lock owner dropped valid: the waiting requester competes next cycle.
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ~RESET_PRIO;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= xfer;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    // A reset in the response cycle kills the pending pulse immediately.
    assign rsp_valid = rsp_valid_q & ~reset;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: table-driven shift vectors plus sequences
// for alternation, locking, reset-after-transfer and idle hold.
module tb_shift_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_data0, req_data1;
    logic [4:0]  req_amt0, req_amt1;
    logic [1:0]  req_arith;
    logic [1:0]  req_lock;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_data;

    int total = 0;
    int bad   = 0;

    shift_arbiter #(.RESET_PRIO(1'b0)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_amt0  (req_amt0),
        .req_amt1  (req_amt1),
        .req_arith (req_arith),
        .req_lock  (req_lock),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic [4:0]  amt;
        logic        arith;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end else begin
            $display("ok   %s act=%h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h80000000, 5'd4,  1'b1, 32'hF8000000};
        vecs[1] = '{1'b0, 32'h80000000, 5'd4,  1'b0, 32'h08000000};
        vecs[2] = '{1'b0, 32'h7FFFFFFF, 5'd0,  1'b1, 32'h7FFFFFFF};
        vecs[3] = '{1'b1, 32'hFFFFFFFF, 5'd31, 1'b0, 32'h00000001};
        vecs[4] = '{1'b1, 32'h80000001, 5'd31, 1'b1, 32'hFFFFFFFF};
        vecs[5] = '{1'b1, 32'h12345678, 5'd8,  1'b0, 32'h00123456};
        vecs[6] = '{1'b0, 32'h87654321, 5'd8,  1'b1, 32'hFF876543};
        vecs[7] = '{1'b1, 32'hF0000000, 5'd1,  1'b0, 32'h78000000};
        vecs[8] = '{1'b0, 32'h7FFFFFFF, 5'd31, 1'b1, 32'h00000000};
        vecs[9] = '{1'b1, 32'hA5A5A5A5, 5'd16, 1'b1, 32'hFFFFA5A5};

        reset     = 1'b1;
        req_valid = 2'b11;
        req_data0 = 32'h11111111;
        req_data1 = 32'h22222222;
        req_amt0  = 5'd1;
        req_amt1  = 5'd2;
        req_arith = 2'b00;
        req_lock  = 2'b00;
        tick();
        tick();
        chk("reset_ready",     {30'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_id",    {31'd0, rsp_id},    32'd0);
        chk("reset_rsp_data",  rsp_data,           32'd0);

        reset     = 1'b0;
        req_valid = 2'b00;
        tick();
        chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Single-requester shift vectors; the idle port carries junk to be ignored.
        for (int k = 0; k < 10; k++) begin
            req_valid = vecs[k].id ? 2'b10 : 2'b01;
            req_data0 = vecs[k].id ? 32'hDEADBEEF : vecs[k].data;
            req_data1 = vecs[k].id ? vecs[k].data : 32'hDEADBEEF;
            req_amt0  = vecs[k].id ? 5'd3 : vecs[k].amt;
            req_amt1  = vecs[k].id ? vecs[k].amt : 5'd3;
            req_arith = vecs[k].id ? {vecs[k].arith, ~vecs[k].arith}
                                   : {~vecs[k].arith, vecs[k].arith};
            #1;
            chk($sformatf("vec%0d_ready", k), {30'd0, req_ready},
                vecs[k].id ? 32'd2 : 32'd1);
            tick();
            req_valid = 2'b00;
            chk($sformatf("vec%0d_rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("vec%0d_rsp_id", k),    {31'd0, rsp_id},    {31'd0, vecs[k].id});
            chk($sformatf("vec%0d_rsp_data", k),  rsp_data,           vecs[k].exp);
        end

        // Idle after a response: no pulse, data and id held.
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("hold%0d_rsp_valid", k), {31'd0, rsp_valid}, 32'd0);
            chk($sformatf("hold%0d_rsp_data", k),  rsp_data, 32'hFFFFA5A5);
            chk($sformatf("hold%0d_rsp_id", k),    {31'd0, rsp_id}, 32'd1);
        end

        // Both valid, no lock, fresh reset: grants alternate starting at 0.
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        req_valid = 2'b11;
        req_lock  = 2'b00;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("alt%0d_ready", k), {30'd0, req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
            if (k > 0) begin
                chk($sformatf("alt%0d_rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
                chk($sformatf("alt%0d_rsp_id", k),    {31'd0, rsp_id}, ((k - 1) % 2 == 0) ? 32'd0 : 32'd1);
            end
            tick();
        end
        req_valid = 2'b00;
        #1;
        chk("alt_last_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("alt_last_rsp_id",    {31'd0, rsp_id},    32'd1);
        tick();

        // Lock: req0 transfers first so req1 wins the next tie, then holds for 3.
        req_valid = 2'b01;
        req_lock  = 2'b00;
        req_data0 = 32'h00000010;
        req_amt0  = 5'd4;
        req_arith = 2'b00;
        tick();
        req_valid = 2'b11;
        req_lock  = 2'b10;
        req_data1 = 32'h80000000;
        req_amt1  = 5'd1;
        req_arith = 2'b10;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("lock%0d_ready", k), {30'd0, req_ready}, 32'd2);
            tick();
            chk($sformatf("lock%0d_rsp_id", k),   {31'd0, rsp_id}, 32'd1);
            chk($sformatf("lock%0d_rsp_data", k), rsp_data, 32'hC0000000);
        end
        req_valid = 2'b01;
        req_lock  = 2'b00;
        #1;
        chk("lock_drop_ready", {30'd0, req_ready}, 32'd0);
        tick();
        chk("lock_after_ready", {30'd0, req_ready}, 32'd1);
        chk("lock_drop_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("lock_after_rsp_id",   {31'd0, rsp_id}, 32'd0);
        chk("lock_after_rsp_data", rsp_data, 32'h00000001);
        req_valid = 2'b00;
        tick();

        // Transfer in N, reset in N+1: the response is suppressed.
        req_valid = 2'b01;
        req_data0 = 32'hFFFF0000;
        req_amt0  = 5'd8;
        req_arith = 2'b00;
        #1;
        chk("rstx_ready", {30'd0, req_ready}, 32'd1);
        tick();
        reset     = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("rstx_n1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rstx_n1_ready",     {30'd0, req_ready}, 32'd0);
        tick();
        reset     = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("rstx_n2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rstx_n2_rsp_data",  rsp_data, 32'd0);

        // Reset while LOCKED(1) releases the lock; tie then goes to RESET_PRIO.
        req_valid = 2'b10;
        req_lock  = 2'b10;
        tick();
        reset     = 1'b1;
        req_valid = 2'b00;
        tick();
        reset     = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("rstlock_ready", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        req_lock  = 2'b00;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
